// File: rtl/move_decoder.sv
// Debounced button-code to valid/ready command converter for the game state logic.
// Define MOVE_DECODER_REPEAT_EN to auto-repeat held direction buttons (1..4).
module move_decoder #(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 12_500_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] code_in,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [6:0] cmd_onehot,
    output logic       cmd_repeat,
    output logic       held,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        HOLD
    } state_t;

    // Reject configurations whose repeat intervals cannot be reached by the counter.
    if (CNT_W < 1 || CNT_W > 32 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        (64'd1 << CNT_W) <= 64'(REPEAT_DELAY) ||
        (64'd1 << CNT_W) <= 64'(REPEAT_PERIOD)) begin : g_bad_params
        $error("move_decoder: CNT_W too small for REPEAT_DELAY/REPEAT_PERIOD");
    end

    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] cur;
    state_t     state;
    state_t     state_n;
    logic       cur_upd;
    logic       evt;
    logic [2:0] evt_code;
    logic       can_issue;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 3'd0;
            s2    <= 3'd0;
            cur   <= 3'd0;
            state <= IDLE;
        end else begin
            s1    <= code_in;
            s2    <= s1;
            state <= state_n;
            if (cur_upd) begin
                cur <= s2;
            end
        end
    end

    // A new code is taken only after two identical consecutive samples.
    assign cur_upd   = (s1 == s2) && (s2 != cur);
    assign held      = (cur != 3'd0);
    assign evt_code  = cur_upd ? s2 : cur;
    assign can_issue = !cmd_valid || cmd_ready;

`ifdef MOVE_DECODER_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             evt_rep;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        evt     = 1'b0;
        evt_rep = 1'b0;
        if (cur_upd) begin
            cnt_n = '0;
            if (s2 == 3'd0) begin
                state_n = IDLE;
            end else begin
                evt     = 1'b1;
                state_n = (s2 <= 3'd4) ? DELAY : HOLD;
            end
        end else begin
            case (state)
                DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        evt     = 1'b1;
                        evt_rep = 1'b1;
                        cnt_n   = '0;
                        state_n = REPEAT;
                    end else if (cnt != '1) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (cnt == PERIOD_LAST) begin
                        evt     = 1'b1;
                        evt_rep = 1'b1;
                        cnt_n   = '0;
                    end else if (cnt != '1) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            cmd_repeat <= 1'b0;
        end else begin
            cnt <= cnt_n;
            if (evt && can_issue) begin
                cmd_repeat <= evt_rep;
            end
        end
    end
`else
    // Without auto-repeat every held code simply parks in HOLD until released.
    always_comb begin
        state_n = state;
        evt     = 1'b0;
        if (cur_upd) begin
            if (s2 == 3'd0) begin
                state_n = IDLE;
            end else begin
                evt     = 1'b1;
                state_n = HOLD;
            end
        end
    end

    assign cmd_repeat = 1'b0;
`endif

    // A pending command is never replaced; an event arriving while it is stuck is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 3'd0;
            overrun   <= 1'b0;
        end else if (evt) begin
            if (can_issue) begin
                cmd_valid <= 1'b1;
                cmd_code  <= evt_code;
            end else begin
                overrun <= 1'b1;
            end
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    always_comb begin
        cmd_onehot = '0;
        if (cmd_valid && (cmd_code != 3'd0)) begin
            cmd_onehot[cmd_code - 3'd1] = 1'b1;
        end
    end

endmodule

// File: tb/tb_move_decoder.sv
// Scoreboard bench for move_decoder: directed presses push expected commands, a monitor checks transfers.
module tb_move_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] code_in;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [6:0] cmd_onehot;
    logic       cmd_repeat;
    logic       held;
    logic       overrun;

    typedef struct {
        logic [2:0] code;
        logic [6:0] onehot;
        logic       rep;
        int         cyc;
        bit         chk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   t0;
    int   t1;

    move_decoder #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .code_in   (code_in),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_onehot(cmd_onehot),
        .cmd_repeat(cmd_repeat),
        .held      (held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] code);
        code_in = code;
    endtask

    task automatic push_exp(input logic [2:0] code, input logic [6:0] oh, input logic rep,
                            input int at, input bit chk);
        exp_t e;
        e.code   = code;
        e.onehot = oh;
        e.rep    = rep;
        e.cyc    = at;
        e.chk    = chk;
        sb.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        check_output({tag, "_code"}, 32'(cmd_code), 32'd0);
        check_output({tag, "_onehot"}, 32'(cmd_onehot), 32'd0);
        check_output({tag, "_repeat"}, 32'(cmd_repeat), 32'd0);
        check_output({tag, "_held"}, 32'(held), 32'd0);
        check_output({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    // Transfers are checked in order; an expected command overdue by a cycle counts as missing.
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("[TB] FAIL unexpected_cmd: got code %0d repeat %0d at cycle %0d, expected none",
                         cmd_code, cmd_repeat, cyc);
            end else begin
                mon_e = sb.pop_front();
                check_output("cmd_code", 32'(cmd_code), 32'(mon_e.code));
                check_output("cmd_onehot", 32'(cmd_onehot), 32'(mon_e.onehot));
                check_output("cmd_repeat", 32'(cmd_repeat), 32'(mon_e.rep));
                if (mon_e.chk) begin
                    check_output("cmd_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
        if (sb.size() > 0 && sb[0].chk && cyc > sb[0].cyc) begin
            total++;
            $display("[TB] FAIL missing_cmd: got nothing by cycle %0d, expected code %0d at cycle %0d",
                     cyc, sb[0].code, sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    initial begin
        reset_n   = 1'b0;
        code_in   = 3'd0;
        cmd_ready = 1'b1;
        tick(2);
        check_idle("reset");
        reset_n = 1'b1;
        tick(20);
        check_idle("idle20");

        // Held "up": one press, then repeats when enabled.
        t0 = cyc;
        apply_stimulus(3'd4);
        push_exp(3'd4, 7'b0001000, 1'b0, t0 + 3, 1'b1);
`ifdef MOVE_DECODER_REPEAT_EN
        push_exp(3'd4, 7'b0001000, 1'b1, t0 + 11, 1'b1);
        push_exp(3'd4, 7'b0001000, 1'b1, t0 + 15, 1'b1);
        push_exp(3'd4, 7'b0001000, 1'b1, t0 + 19, 1'b1);
`endif
        tick(3);
        check_output("held_up", 32'(held), 32'd1);
        tick(15);
        apply_stimulus(3'd0);
        tick(5);
        check_output("held_release", 32'(held), 32'd0);

        // Decision button never repeats.
        t0 = cyc;
        apply_stimulus(3'd5);
        push_exp(3'd5, 7'b0010000, 1'b0, t0 + 3, 1'b1);
        tick(30);
        apply_stimulus(3'd0);
        tick(6);

        // One-cycle glitch is filtered out.
        apply_stimulus(3'd2);
        tick(1);
        apply_stimulus(3'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_output("glitch_held", 32'(held), 32'd0);
            check_output("glitch_valid", 32'(cmd_valid), 32'd0);
        end

        // Back-pressure: second press is dropped and flagged.
        cmd_ready = 1'b0;
        apply_stimulus(3'd1);
        tick(3);
        check_output("bp_valid", 32'(cmd_valid), 32'd1);
        check_output("bp_code", 32'(cmd_code), 32'd1);
        check_output("bp_onehot", 32'(cmd_onehot), 32'b0000001);
        check_output("bp_overrun_before", 32'(overrun), 32'd0);
        apply_stimulus(3'd3);
        tick(3);
        check_output("bp_overrun", 32'(overrun), 32'd1);
        check_output("bp_code_stable", 32'(cmd_code), 32'd1);
        check_output("bp_valid_held", 32'(cmd_valid), 32'd1);
        apply_stimulus(3'd0);
        tick(3);
        push_exp(3'd1, 7'b0000001, 1'b0, 0, 1'b0);
        cmd_ready = 1'b1;
        tick(1);
        check_output("bp_valid_fall", 32'(cmd_valid), 32'd0);
        check_output("bp_overrun_sticky", 32'(overrun), 32'd1);

        // Changing code while held is a new press.
        t0 = cyc;
        apply_stimulus(3'd4);
        push_exp(3'd4, 7'b0001000, 1'b0, t0 + 3, 1'b1);
        tick(3);
        apply_stimulus(3'd2);
        push_exp(3'd2, 7'b0000010, 1'b0, t0 + 6, 1'b1);
        tick(4);
        apply_stimulus(3'd0);
        tick(6);

        // Reset mid-hold clears everything; the still-held button re-presses.
        t0 = cyc;
        apply_stimulus(3'd1);
        push_exp(3'd1, 7'b0000001, 1'b0, t0 + 3, 1'b1);
`ifdef MOVE_DECODER_REPEAT_EN
        push_exp(3'd1, 7'b0000001, 1'b1, t0 + 11, 1'b1);
`endif
        tick(13);
        reset_n = 1'b0;
        #1;
        check_idle("midreset");
        tick(2);
        reset_n = 1'b1;
        t1 = cyc;
        push_exp(3'd1, 7'b0000001, 1'b0, t1 + 3, 1'b1);
        tick(5);
        apply_stimulus(3'd0);
        tick(10);

        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
